// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multi-cycle MIPS-like core.
//   Opcode constants, instruction field positions, FSM state encoding,
//   ALU operation codes and small decode helpers.
package mips_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_INC  = 6'b000011;
    localparam logic [5:0] OP_DEC  = 6'b000100;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_XOR  = 6'b000111;
    localparam logic [5:0] OP_NOT  = 6'b001000;
    localparam logic [5:0] OP_SLL  = 6'b001001;
    localparam logic [5:0] OP_SRL  = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100010;
    localparam logic [5:0] OP_SW   = 6'b100100;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Low bit of each instruction field
    localparam int OP_LSB = 26;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;
    localparam int SH_LSB = 6;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOT, ALU_SLL, ALU_SRL
    } alu_op_t;

    // LW/SW (and anything unknown) use ADD for the effective address.
    function automatic alu_op_t alu_op_of(input logic [5:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_INC:  return ALU_INC;
            OP_DEC:  return ALU_DEC;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_NOT:  return ALU_NOT;
            OP_SLL:  return ALU_SLL;
            OP_SRL:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

    // Three-register forms write rd; all other writers target rt.
    function automatic logic is_rtype(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return is_rtype(op) || (op == OP_INC) || (op == OP_DEC) ||
               (op == OP_NOT) || (op == OP_SLL) || (op == OP_SRL) ||
               (op == OP_LW) || (op == OP_SW) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/mips_alu.sv
// mips_alu: combinational ALU, DATA_W wide, all arithmetic wraps.
//   op    : operation select (alu_op_t)
//   a, b  : operands (b unused by the single-operand ops)
//   shamt : shift amount; values >= DATA_W shift everything out
//   y     : result
module mips_alu
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    output logic [DATA_W-1:0] y
);

    logic shift_out;
    assign shift_out = (int'(shamt) >= DATA_W);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_INC: y = a + DATA_W'(1);
            ALU_DEC: y = a - DATA_W'(1);
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_NOT: y = ~a;
            ALU_SLL: y = shift_out ? '0 : (a << shamt);
            ALU_SRL: y = shift_out ? '0 : (a >> shamt);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: self-contained multi-cycle core with its own PC,
// instruction memory, register file and data memory.
//   clk/rst     : rising-edge clock, synchronous active-high reset
//   start       : begin execution at PC 0 (from IDLE or HALT only)
//   host_*      : preload port; sel 0 = imem (32-bit words), 1 = dmem;
//                 honoured only while idle or halted
//   dbg_raddr/dbg_rdata : combinational register-file read
//   busy/halted/err/pc/retired : status
// Optional feature macro: MIPS_ILLEGAL_TRAP_EN -- illegal opcodes halt with
// err=1 and pc at the offending word; otherwise they retire as 3-cycle NOPs.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    host_we,
    input  logic                    host_sel,
    input  logic [$clog2((IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH)-1:0] host_addr,
    input  logic [31:0]             host_wdata,
    input  logic [REG_ADDR_W-1:0]   dbg_raddr,
    output logic [DATA_W-1:0]       dbg_rdata,
    output logic                    busy,
    output logic                    halted,
    output logic                    err,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic [31:0]             retired
);

    localparam int PC_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);

    state_t state, state_nxt;

    logic [31:0]           imem [IMEM_DEPTH];
    logic [DATA_W-1:0]     dmem [DMEM_DEPTH];
    logic [DATA_W-1:0]     rf   [2**REG_ADDR_W];

    logic [31:0]           ir;
    logic [DATA_W-1:0]     a_q, b_q, res_q, alu_b, alu_y, imm_x;

    // Instruction fields
    logic [5:0]            op;
    logic [REG_ADDR_W-1:0] rs, rt, rd, dst;
    logic [4:0]            shamt;
    logic [DA_W-1:0]       ea;

    assign op    = ir[OP_LSB +: 6];
    assign rs    = ir[RS_LSB +: REG_ADDR_W];
    assign rt    = ir[RT_LSB +: REG_ADDR_W];
    assign rd    = ir[RD_LSB +: REG_ADDR_W];
    assign shamt = ir[SH_LSB +: 5];
    assign imm_x = DATA_W'({{16{ir[15]}}, ir[15:0]});
    assign dst   = is_rtype(op) ? rd : rt;
    assign ea    = res_q[DA_W-1:0];   // effective address wraps in dmem

    // Memory ops add the immediate; everything else uses rt
    assign alu_b = ((op == OP_LW) || (op == OP_SW)) ? imm_x : b_q;

    mips_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (alu_op_of(op)),
        .a     (a_q),
        .b     (alu_b),
        .shamt (shamt),
        .y     (alu_y)
    );

    assign dbg_rdata = rf[dbg_raddr];

    // Control strobes from the output process
    logic host_ok, go, retire, rf_we, dmem_we, trap;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (op == OP_HALT)                     state_nxt = S_HALT;
                else if (!is_legal(op))
`ifdef MIPS_ILLEGAL_TRAP_EN
                                                       state_nxt = S_HALT;
`else
                                                       state_nxt = S_FETCH;
`endif
                else if (op == OP_LW || op == OP_SW)   state_nxt = S_MEM;
                else                                   state_nxt = S_WB;
            end
            S_MEM:    state_nxt = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        host_ok = (state == S_IDLE) || (state == S_HALT);
        busy    = !host_ok;
        halted  = (state == S_HALT);
        go      = host_ok && start;
        rf_we   = (state == S_WB);
        // rst wins over a store landing in the same edge
        dmem_we = (state == S_MEM) && (op == OP_SW) && !rst;
`ifdef MIPS_ILLEGAL_TRAP_EN
        trap    = (state == S_EXEC) && !is_legal(op);
`else
        trap    = 1'b0;
`endif
        retire  = rf_we || ((state == S_MEM) && (op == OP_SW)) ||
                  ((state == S_EXEC) && !is_legal(op) && !trap);
    end

    // ---------------- datapath and architectural state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            retired <= '0;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            for (int i = 0; i < 2**REG_ADDR_W; i++) rf[i] <= '0;
        end else begin
            if (go) pc <= '0;
            case (state)
                S_FETCH:  ir <= imem[pc];
                S_DECODE: begin
                    a_q <= rf[rs];
                    b_q <= rf[rt];
                end
                S_EXEC:   res_q <= alu_y;
                S_MEM:    if (op == OP_LW) res_q <= dmem[ea];
                default:  ;
            endcase
            if (rf_we) rf[dst] <= res_q;
            if (retire) begin
                pc <= pc + PC_W'(1);
                if (retired != '1) retired <= retired + 32'd1;
            end
        end
    end

    // Memories are not reset; host and SW writes are mutually exclusive by state
    always_ff @(posedge clk) begin
        if (host_ok && host_we && !host_sel) imem[host_addr[PC_W-1:0]] <= host_wdata;
        if (host_ok && host_we && host_sel)  dmem[host_addr[DA_W-1:0]] <= host_wdata[DATA_W-1:0];
        else if (dmem_we)                    dmem[ea] <= b_q;
    end

`ifdef MIPS_ILLEGAL_TRAP_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst || go) err_q <= 1'b0;
        else if (trap) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: randomized and directed checks of the core
// (DATA_W=8, 32 registers, 64-word memories) against an instruction-level
// reference model. Honours MIPS_ILLEGAL_TRAP_EN when defined.
module tb_mips_multicycle_core;

    localparam logic [5:0] T_ADD = 6'b000001, T_SUB = 6'b000010, T_INC = 6'b000011,
                           T_DEC = 6'b000100, T_AND = 6'b000101, T_OR  = 6'b000110,
                           T_XOR = 6'b000111, T_NOT = 6'b001000, T_SLL = 6'b001001,
                           T_SRL = 6'b001010, T_LW  = 6'b100010, T_SW  = 6'b100100,
                           T_HALT = 6'b111111, T_ILL = 6'b010101;
`ifdef MIPS_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, host_we = 1'b0, host_sel = 1'b0;
    logic [5:0]  host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic [4:0]  dbg_raddr = '0;
    logic [7:0]  dbg_rdata;
    logic        busy, halted, err;
    logic [5:0]  pc;
    logic [31:0] retired;

    always #5 clk = ~clk;

    mips_multicycle_core #(.DATA_W(8), .REG_ADDR_W(5), .IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .host_we(host_we), .host_sel(host_sel),
        .host_addr(host_addr), .host_wdata(host_wdata), .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata), .busy(busy), .halted(halted), .err(err), .pc(pc),
        .retired(retired)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    logic [31:0] m_imem [64];
    logic [7:0]  m_dmem [64];
    logic [7:0]  m_rf   [32];
    int          m_pc, m_retired;
    bit          m_halted, m_err;

    task automatic model_run();
        logic [31:0] w;
        logic [5:0]  op;
        logic [7:0]  a, b, s8;
        int rs, rt, rd, sh, ea;
        bit legal;
        m_pc = 0; m_err = 0; m_halted = 0;
        for (int s = 0; s < 1000 && !m_halted; s++) begin
            w = m_imem[m_pc]; op = w[31:26];
            rs = int'(w[25:21]); rt = int'(w[20:16]); rd = int'(w[15:11]); sh = int'(w[10:6]);
            a = m_rf[rs]; b = m_rf[rt];
            s8 = a + w[7:0];          // imm sign-extended to 8 bits is its low byte
            ea = int'(s8[5:0]);
            legal = 1;
            case (op)
                T_ADD: m_rf[rd] = a + b;
                T_SUB: m_rf[rd] = a - b;
                T_AND: m_rf[rd] = a & b;
                T_OR:  m_rf[rd] = a | b;
                T_XOR: m_rf[rd] = a ^ b;
                T_INC: m_rf[rt] = a + 8'd1;
                T_DEC: m_rf[rt] = a - 8'd1;
                T_NOT: m_rf[rt] = ~a;
                T_SLL: m_rf[rt] = (sh >= 8) ? 8'd0 : 8'(a << sh);
                T_SRL: m_rf[rt] = (sh >= 8) ? 8'd0 : 8'(a >> sh);
                T_LW:  m_rf[rt] = m_dmem[ea];
                T_SW:  m_dmem[ea] = b;
                T_HALT: m_halted = 1;
                default: legal = 0;
            endcase
            if (!m_halted) begin
                if (!legal && TRAP) begin
                    m_halted = 1; m_err = 1;
                end else begin
                    m_pc = (m_pc + 1) % 64;
                    m_retired++;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        for (int r = 0; r < 32; r++) m_rf[r] = '0;
        m_retired = 0; m_pc = 0;
    endtask

    task automatic hw(input bit sel, input int addr, input logic [31:0] d);
        host_we = 1'b1; host_sel = sel; host_addr = 6'(addr); host_wdata = d;
        step();
        host_we = 1'b0;
        if (sel) m_dmem[addr] = d[7:0];
        else     m_imem[addr] = d;
    endtask

    task automatic go();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 3000) begin step(); n++; end
        chk(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic rd_reg(input int r, output logic [7:0] v);
        dbg_raddr = 5'(r); #1; v = dbg_rdata;
    endtask

    task automatic chk_state(input string tag);
        logic [7:0] v;
        chk({tag, "_retired"}, retired, 32'(m_retired));
        chk({tag, "_pc"}, {26'd0, pc}, 32'(m_pc));
        chk({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
        for (int r = 0; r < 32; r++) begin
            rd_reg(r, v);
            chk($sformatf("%s_r%0d", tag, r), {24'd0, v}, {24'd0, m_rf[r]});
        end
    endtask

    function automatic logic [31:0] ei(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] er(input logic [5:0] op, input int rs, input int rt, input int rd, input int sh);
        return {op, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'd0};
    endfunction

    logic [5:0] optab [12] = '{T_ADD, T_SUB, T_INC, T_DEC, T_AND, T_OR,
                               T_XOR, T_NOT, T_SLL, T_SRL, T_LW, T_SW};

    initial begin
        logic [7:0]  v;
        logic [31:0] w;
        int n, len, k;

        // ---- reset state ----
        step(); step(); rst = 1'b0; step();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_pc", {26'd0, pc}, 0);
        chk("rst_retired", retired, 0);
        chk("rst_err", {31'd0, err}, 0);
        rd_reg(0, v);  chk("rst_r0", {24'd0, v}, 0);
        rd_reg(31, v); chk("rst_r31", {24'd0, v}, 0);
        do_reset();

        // ---- load/add/halt program with latency check ----
        hw(1, 1, 5); hw(1, 2, 7);
        hw(0, 0, ei(T_LW, 1, 0, 1));
        hw(0, 1, ei(T_LW, 2, 1, 2));
        hw(0, 2, er(T_ADD, 0, 1, 3, 0));
        hw(0, 3, {T_HALT, 26'd0});
        model_run();
        go();
        n = 0;
        while (retired != 3 && n < 200) begin step(); n++; end
        chk("lat_ret3", n, 14);
        wait_halt("tp_halt");
        rd_reg(3, v); chk("tp_r3", {24'd0, v}, 12);
        chk("tp_busy", {31'd0, busy}, 0);
        chk_state("tp");

        // ---- ALU boundaries at DATA_W=8 ----
        do_reset();
        hw(1, 8, 9); hw(1, 9, 10); hw(1, 10, 8'hFF); hw(1, 11, 5); hw(1, 12, 8);
        k = 0;
        hw(0, k++, ei(T_LW, 0, 1, 8));
        hw(0, k++, ei(T_LW, 0, 2, 9));
        hw(0, k++, er(T_SUB, 1, 2, 6, 0));
        hw(0, k++, ei(T_LW, 0, 3, 10));
        hw(0, k++, er(T_INC, 3, 7, 0, 0));
        hw(0, k++, ei(T_LW, 0, 4, 11));
        hw(0, k++, er(T_DEC, 4, 8, 0, 0));
        hw(0, k++, er(T_SLL, 4, 9, 0, 2));
        hw(0, k++, ei(T_LW, 0, 5, 12));
        hw(0, k++, er(T_SRL, 5, 10, 0, 2));
        hw(0, k++, er(T_NOT, 0, 11, 0, 0));
        hw(0, k++, er(T_SLL, 4, 12, 0, 9));
        hw(0, k++, {T_HALT, 26'd0});
        model_run();
        go(); wait_halt("alu_halt");
        rd_reg(6, v);  chk("sub_9_10", {24'd0, v}, 32'hFF);
        rd_reg(7, v);  chk("inc_ff", {24'd0, v}, 0);
        rd_reg(8, v);  chk("dec_5", {24'd0, v}, 4);
        rd_reg(9, v);  chk("sll_5_2", {24'd0, v}, 20);
        rd_reg(10, v); chk("srl_8_2", {24'd0, v}, 2);
        rd_reg(11, v); chk("not_0", {24'd0, v}, 32'hFF);
        rd_reg(12, v); chk("sll_big", {24'd0, v}, 0);
        chk_state("alu");

        // ---- SW address wrap ----
        do_reset();
        hw(1, 20, 8'h5A); hw(1, 3, 8'h11);
        hw(0, 0, ei(T_LW, 0, 5, 20));
        hw(0, 1, ei(T_SW, 0, 5, 67));
        hw(0, 2, ei(T_LW, 0, 7, 3));
        hw(0, 3, {T_HALT, 26'd0});
        model_run();
        go(); wait_halt("sw_halt");
        rd_reg(7, v); chk("sw_wrap", {24'd0, v}, 32'h5A);
        chk_state("sw");

        // ---- host write and start while busy are ignored ----
        do_reset();
        for (int i = 0; i < 5; i++) hw(0, i, er(T_INC, 1, 1, 0, 0));
        hw(0, 5, {T_HALT, 26'd0});
        model_run();
        go();                      // now in cycle 0
        step(); step();            // cycle 2
        host_we = 1'b1; host_sel = 1'b0; host_addr = 6'd3; host_wdata = {T_HALT, 26'd0};
        step(); host_we = 1'b0;    // cycle 3
        step(); step(); step(); step();
        go();                      // cycle 8
        chk("busy_start_pc", {26'd0, pc}, 2);
        chk("busy_busy", {31'd0, busy}, 1);
        wait_halt("busy_halt");
        rd_reg(1, v); chk("busy_r1", {24'd0, v}, 5);
        chk_state("busy");
        // restart from HALT keeps registers and retired count
        model_run();
        go(); wait_halt("rest_halt");
        chk_state("rest");
        // write and start in the same cycle: first fetch sees the new word
        host_we = 1'b1; host_sel = 1'b0; host_addr = 6'd0; host_wdata = {T_HALT, 26'd0}; start = 1'b1;
        step(); host_we = 1'b0; start = 1'b0;
        m_imem[0] = {T_HALT, 26'd0};
        model_run();
        wait_halt("ws_halt");
        chk_state("ws");

        // ---- reset during the MEM cycle of a store ----
        do_reset();
        hw(1, 1, 8'h77); hw(1, 10, 8'h33);
        hw(0, 0, ei(T_LW, 0, 5, 1));
        hw(0, 1, ei(T_SW, 0, 5, 10));
        hw(0, 2, {T_HALT, 26'd0});
        go();
        for (int i = 0; i < 8; i++) step();   // cycle 8: MEM of SW
        chk("rstm_pre_ret", retired, 1);
        rst = 1'b1; step();
        chk("rstm_busy", {31'd0, busy}, 0);
        chk("rstm_pc", {26'd0, pc}, 0);
        chk("rstm_ret", retired, 0);
        rd_reg(5, v); chk("rstm_r5", {24'd0, v}, 0);
        rst = 1'b0; step();
        for (int r = 0; r < 32; r++) m_rf[r] = '0;
        m_retired = 0;
        hw(0, 0, ei(T_LW, 0, 2, 10));
        hw(0, 1, {T_HALT, 26'd0});
        model_run();
        go(); wait_halt("rstm_halt");
        rd_reg(2, v); chk("rstm_dmem", {24'd0, v}, 32'h33);

        // ---- illegal opcode ----
        do_reset();
        hw(0, 0, er(T_INC, 1, 1, 0, 0));
        hw(0, 1, er(T_ILL, 0, 0, 0, 0));
        hw(0, 2, er(T_INC, 1, 1, 0, 0));
        hw(0, 3, {T_HALT, 26'd0});
        model_run();
        go(); wait_halt("ill_halt");
        chk("ill_ret", retired, TRAP ? 32'd1 : 32'd3);
        chk("ill_pc", {26'd0, pc}, TRAP ? 32'd1 : 32'd3);
        chk("ill_err", {31'd0, err}, {31'd0, TRAP});
        chk_state("ill");
        go();
        chk("ill_errclr", {31'd0, err}, 0);
        wait_halt("ill_halt2");

        // ---- randomized programs ----
        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int a = 0; a < 64; a++) hw(1, a, $urandom);
            len = $urandom_range(8, 24);
            for (int i = 0; i < len; i++) begin
                k = $urandom_range(0, 16);
                w = $urandom;
                w[31:26] = (k < 12) ? optab[k] : (k < 16) ? T_LW : T_ILL;
                w[25:21] = 5'($urandom_range(0, 7));
                w[20:16] = 5'($urandom_range(0, 7));
                w[15:11] = 5'($urandom_range(0, 7));
                hw(0, i, w);
            end
            hw(0, len, {T_HALT, 26'd0});
            model_run();
            go(); wait_halt($sformatf("rnd%0d_halt", it));
            chk_state($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Self-contained, parametrised multi-cycle successor to the single-cycle datapath/controller pair.
- Owns its PC, instruction memory, register file and data memory; sequences each instruction through a state machine instead of taking one externally driven instruction per clock.
- The host preloads both memories, pulses start, and observes busy/halted/retired plus a debug register-read port.

Parameters:
- DATA_W, 32, register/ALU/data-memory word width; legal range 8..32.
- REG_ADDR_W, 5, register index width; the file holds 2**REG_ADDR_W registers.
- IMEM_DEPTH, 64, instruction words; power of two.
- DMEM_DEPTH, 64, data words; power of two.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution from PC 0.
- host_we  in  1  host memory write strobe.
- host_sel  in  1  0 = instruction memory, 1 = data memory.
- host_addr  in  $clog2(max(IMEM_DEPTH,DMEM_DEPTH))  word address.
- host_wdata  in  32  write data; the data memory takes bits [DATA_W-1:0].
- dbg_raddr  in  REG_ADDR_W  debug register index.
- dbg_rdata  out  DATA_W  combinational read of regfile[dbg_raddr].
- busy  out  1  high in any state other than IDLE and HALT.
- halted  out  1  high in the HALT state.
- err  out  1  illegal-opcode flag (see Optional Feature).
- pc  out  $clog2(IMEM_DEPTH)  current PC, word address.
- retired  out  32  count of completed instructions.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pc=0, retired=0, err=0, all registers 0, busy=0, halted=0. Memory contents are not reset.
- Encoding (32-bit): op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], imm[15:0]. imm is sign-extended to DATA_W. Register fields use the low REG_ADDR_W bits.
- Opcodes and results:
  - ADD 000001, SUB 000010, AND 000101, OR 000110, XOR 000111: rd <- rs op rt.
  - INC 000011: rt <- rs+1. DEC 000100: rt <- rs-1. NOT 001000: rt <- ~rs.
  - SLL 001001 / SRL 001010: rt <- rs shifted by shamt (logical; shamt >= DATA_W gives 0).
  - LW 100010: rt <- dmem[rs+imm]. SW 100100: dmem[rs+imm] <- rt.
  - HALT 111111: enter HALT.
- Arithmetic wraps modulo 2**DATA_W. Data-memory address = low $clog2(DMEM_DEPTH) bits of rs+imm (wraps). Register 0 is an ordinary writable register.
- State machine:
  - IDLE: waits for start. start -> FETCH with pc=0.
  - FETCH: ir <- imem[pc].
  - DECODE: latch operands A=rs, B=rt.
  - EXEC: ALU result or effective address. HALT opcode -> HALT.
  - MEM: LW reads, SW writes.
  - WB: write destination register.
- Per-instruction latency: ALU ops 4 cycles (F,D,E,WB); LW 5 (F,D,E,M,WB); SW 4 (F,D,E,M).
- In the final cycle of each instruction: pc <- pc+1, wrapping at IMEM_DEPTH; retired increments, saturating at 2**32-1. HALT does not count as retired.
- HALT: busy=0, halted=1. start -> FETCH with pc=0; retired and registers are kept.
- Host writes are honoured only in IDLE or HALT and ignored while busy. When host_sel=0, only 32-bit words are written.
- start while busy is ignored. start and host_we in the same cycle: the write lands, then execution begins; the first FETCH sees the new word.
- rst mid-instruction aborts it; any pending register write or SW is discarded.
- Illegal opcode without the macro: NOP that still retires, in 3 cycles (F,D,E).

Optional Feature:
- Macro: MIPS_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in EXEC goes to HALT with err=1 and pc left pointing at the offending word. The instruction does not retire. err clears on rst or start.
- Undefined: err is tied to 0 and illegal opcodes behave as NOPs.

Decomposition:
- Shared package mips_pkg: opcode localparams (ADD..SW, HALT), state enum encoding, field bit-position constants, and the ALU-op code type shared with the existing controller.
- One natural sub-module: mips_alu (DATA_W-parametrised, combinational; ops ADD/SUB/INC/DEC/AND/OR/XOR/NOT/SLL/SRL). Regfile and memories stay inline.

Test Plan:
- Preload dmem[1]=5, dmem[2]=7. Program: LW r0,r1+1 (r1=0 gives dmem[1]); LW r1,r2+2 (dmem[2]); ADD rd=r3,rs=r0,rt=r1; HALT -> r3=12, retired=3, halted=1, total cycles from start = 5+5+4+1.
- SUB 9-10 with DATA_W=8 -> r6=0xFF. INC 0xFF -> 0x00. DEC 5 -> 4. SLL 5 by 2 -> 20. SRL 8 by 2 -> 2. NOT 0 -> all ones.
- SW r5 to address rs+imm = DMEM_DEPTH+3 -> the write wraps to dmem[3]; a following LW from 3 returns the r5 value.
- host_we asserted while busy -> imem unchanged. start while busy -> no restart, pc continues.
- rst asserted during MEM of an SW -> dmem unchanged, pc=0, registers 0, busy=0 the next cycle.
- Opcode 010101: with MIPS_ILLEGAL_TRAP_EN -> halted=1, err=1, pc=address of the offending word. Without it -> retired increments and the next instruction executes.
